// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: broadcasts an input vector to all neurons,
// gathers their output pulses and drains the results. Optional LAYER_SEQ_ARGMAX_EN.
module layer_sequencer #(
    parameter int NUM_NEURON = 30,
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            n_data,
    output logic                             n_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] n_out_data,
    input  logic [NUM_NEURON-1:0]            n_out_valid,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last,
`ifdef LAYER_SEQ_ARGMAX_EN
    output logic [(NUM_NEURON > 1 ? $clog2(NUM_NEURON) : 1)-1:0] class_idx,
    output logic                             class_valid,
`endif
    output logic                             busy,
    output logic                             err
);

    localparam int IW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int CW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WEIGHT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_NEURON - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         idx_nx;
    logic [NUM_NEURON-1:0] done_q, done_d;
    logic [NUM_NEURON-1:0] done_n;
    logic [DATA_WIDTH-1:0] result_q [NUM_NEURON];
    logic [DATA_WIDTH-1:0] result_d [NUM_NEURON];
    logic                  s_ready_q, s_ready_d;
    logic                  n_valid_q, n_valid_d;
    logic [DATA_WIDTH-1:0] n_data_q, n_data_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        idx_nx    = idx_q + 1'b1;
        done_d    = done_q;
        done_n    = done_q | n_out_valid;
        result_d  = result_q;
        s_ready_d = s_ready_q;
        n_valid_d = 1'b0;
        n_data_d  = n_data_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        err_d     = err_q;

        // Pulses outside WAIT have no owner; flag them and drop the data.
        if (state_q != S_WAIT && |n_out_valid) err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d   = S_FEED;
                    s_ready_d = 1'b1;
                end
            end
            S_FEED: begin
                if (s_valid && s_ready_q) begin
                    n_valid_d = 1'b1;
                    n_data_d  = s_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        s_ready_d = 1'b0;
                        state_d   = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                for (int k = 0; k < NUM_NEURON; k++) begin
                    if (n_out_valid[k]) begin
                        result_d[k] = n_out_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                done_d = done_n;
                if (&done_n) begin
                    done_d    = '0;
                    state_d   = S_DRAIN;
                    idx_d     = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = result_d[0];
                    m_last_d  = (NUM_NEURON == 1);
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    if (idx_q == IDX_LAST) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        idx_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        idx_d    = idx_nx;
                        m_data_d = result_q[idx_nx];
                        m_last_d = (idx_nx == IDX_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            done_q    <= '0;
            s_ready_q <= 1'b0;
            n_valid_q <= 1'b0;
            n_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < NUM_NEURON; k++) result_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            n_valid_q <= n_valid_d;
            n_data_q  <= n_data_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            for (int k = 0; k < NUM_NEURON; k++) result_q[k] <= result_d[k];
        end
    end

    assign s_ready = s_ready_q;
    assign n_valid = n_valid_q;
    assign n_data  = n_data_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign err     = err_q;

`ifdef LAYER_SEQ_ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IW-1:0]         best_q, best_d;
    logic [IW-1:0]         win;
    logic [IW-1:0]         class_idx_q, class_idx_d;
    logic                  class_valid_q, class_valid_d;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        max_d         = max_q;
        best_d        = best_q;
        win           = best_q;
        class_idx_d   = class_idx_q;
        class_valid_d = 1'b0;
        if (state_q == S_DRAIN && m_ready) begin
            if (idx_q == '0 || $signed(m_data_q) > $signed(max_q)) begin
                max_d  = m_data_q;
                best_d = idx_q;
                win    = idx_q;
            end
            if (idx_q == IDX_LAST) begin
                class_idx_d   = win;
                class_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q         <= '0;
            best_q        <= '0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            max_q         <= max_d;
            best_q        <= best_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: random frames, bench-side neurons,
// queue-based expectations popped by an independent monitor.
module tb_layer_sequencer;

    localparam int NN = 4;
    localparam int NW = 8;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     n_data;
    logic              n_valid;
    logic [NN*DW-1:0]  n_out_data;
    logic [NN-1:0]     n_out_valid;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              err;
`ifdef LAYER_SEQ_ARGMAX_EN
    logic [1:0]        class_idx;
    logic              class_valid;
    int                exp_cls[$];
`endif

    layer_sequencer #(.NUM_NEURON(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .n_data(n_data), .n_valid(n_valid),
        .n_out_data(n_out_data), .n_out_valid(n_out_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
`ifdef LAYER_SEQ_ARGMAX_EN
        .class_idx(class_idx), .class_valid(class_valid),
`endif
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_pulse_cyc = 0;
    int strobe_tot = 0;
    int hs_tot = 0;
    int rdy_mode = 0;
    int frame_id = 0;
    logic exp_err = 1'b0;

    logic [DW-1:0] vals [NN];
    logic [DW-1:0] want [NN];
    logic [DW-1:0] exp_n[$];
    logic [DW:0]   exp_m[$];

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always_comb begin
        n_out_data = '0;
        for (int k = 0; k < NN; k++) n_out_data[k*DW +: DW] = vals[k];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready driver
    initial begin
        int seen;
        int stl;
        seen = -1;
        stl = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (frame_id != seen) begin
                seen = frame_id;
                stl = 0;
            end
            case (rdy_mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (m_valid && hs_tot % NN == 1 && stl < 3) begin
                        m_ready = 1'b0;
                        stl++;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    initial begin
        int acc_fr;
        int post;
        logic chk_rdy, stall, prev_mv, hold_last;
        logic [DW-1:0] hold_data;
        logic [DW:0] e;
        acc_fr = 0; post = 0;
        chk_rdy = 0; stall = 0; prev_mv = 0;
        hold_last = 0; hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_n.delete();
                acc_fr = 0; post = 0;
                chk_rdy = 0; stall = 0; prev_mv = 0;
            end else begin
                if (n_valid) begin
                    strobe_tot++;
                    if (exp_n.size() == 0) chk("n_valid_extra", 1, 0);
                    else chk("n_data", n_data, exp_n.pop_front());
                end
                if (chk_rdy) begin
                    chk("s_ready_drop", s_ready, 0);
                    chk_rdy = 0;
                end
                if (s_valid && s_ready) begin
                    exp_n.push_back(s_data);
                    acc_fr++;
                    if (acc_fr == NW) begin
                        acc_fr = 0;
                        chk_rdy = 1;
                    end
                end
                if (stall)
                    chk("m_hold", {m_valid, m_last, m_data}, {1'b1, hold_last, hold_data});
                if (m_valid && !prev_mv)
                    chk("m_valid_latency", cyc, last_pulse_cyc + 1);
                if (m_valid) chk("busy_drain", busy, 1);
                if (post == 1) begin
                    chk("busy_after", busy, 0);
                    chk("m_valid_after", m_valid, 0);
`ifdef LAYER_SEQ_ARGMAX_EN
                    chk("class_valid", class_valid, 1);
                    if (exp_cls.size() != 0) chk("class_idx", class_idx, exp_cls.pop_front());
`endif
                    post = 2;
                end else if (post == 2) begin
`ifdef LAYER_SEQ_ARGMAX_EN
                    chk("class_valid_pulse", class_valid, 0);
`endif
                    post = 0;
                end
                if (m_valid && m_ready) begin
                    hs_tot++;
                    if (exp_m.size() == 0) begin
                        chk("m_extra", 1, 0);
                    end else begin
                        e = exp_m.pop_front();
                        chk("m_data", $signed(m_data), $signed(e[DW-1:0]));
                        chk("m_last", m_last, e[DW]);
                    end
                    if (m_last) post = 1;
                end
                stall = m_valid && !m_ready;
                hold_data = m_data;
                hold_last = m_last;
                prev_mv = m_valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [NN-1:0] m);
        n_out_valid = m;
        last_pulse_cyc = cyc;
        tick(1);
        n_out_valid = '0;
    endtask

    task automatic feed(input int n, input int mode);
        bit ok;
        int gap;
        for (int i = 0; i < n; i++) begin
            s_data = DW'($urandom);
            s_valid = 1'b1;
            ok = 0;
            for (int w = 0; w < 50; w++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                chk("s_ready_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            tick(1);
            if (mode == 1) begin
                s_valid = 1'b0;
                tick(1);
            end else if (mode == 2) begin
                gap = $urandom_range(0, 2);
                if (gap != 0) begin
                    s_valid = 1'b0;
                    tick(gap);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    // fm: 0 held, 1 toggle, 2 random gaps; pm: 0 together, 1 staggered, 2 random
    task automatic frame(input int fm, input int pm, input int rm, input bit inj);
        int base_s, base_h, best;
        logic [NN-1:0] rem, m;
        rdy_mode = rm;
        frame_id++;
        base_s = strobe_tot;
        base_h = hs_tot;
        for (int k = 0; k < NN; k++) begin
            vals[k] = DW'($urandom);
            exp_m.push_back({1'(k == NN - 1), want[k]});
        end
        best = 0;
        for (int k = 1; k < NN; k++)
            if ($signed(want[k]) > $signed(want[best])) best = k;
`ifdef LAYER_SEQ_ARGMAX_EN
        exp_cls.push_back(best);
`endif
        fork
            feed(NW, fm);
            if (inj) begin
                tick(3);
                pulse(4'b0010);
                exp_err = 1'b1;
            end
        join
        for (int i = 0; i < 100; i++) begin
            if (strobe_tot - base_s >= NW) break;
            tick(1);
        end
        chk("strobe_count", strobe_tot - base_s, NW);
        for (int k = 0; k < NN; k++) vals[k] = want[k];
        case (pm)
            0: pulse('1);
            1: begin
                vals[0] = ~want[0];
                pulse(4'b0100);
                tick(2);
                pulse(4'b0001);
                vals[0] = want[0];
                pulse(4'b0001);
                pulse(4'b1010);
            end
            default: begin
                rem = '1;
                while (rem != '0) begin
                    m = NN'($urandom) & rem;
                    if (m != '0) begin
                        pulse(m);
                        rem &= ~m;
                    end
                    tick($urandom_range(0, 1));
                end
            end
        endcase
        for (int i = 0; i < 200; i++) begin
            if (hs_tot - base_h >= NN) break;
            tick(1);
        end
        chk("drain_count", hs_tot - base_h, NN);
        tick(3);
        chk("strobe_total", strobe_tot - base_s, NW);
        chk("exp_m_empty", exp_m.size(), 0);
        chk("err_flag", err, exp_err);
    endtask

    task automatic set_want(input int a, input int b, input int c, input int d);
        want[0] = DW'(a);
        want[1] = DW'(b);
        want[2] = DW'(c);
        want[3] = DW'(d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_n_valid"}, n_valid, 0);
        chk({tag, "_n_data"}, n_data, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        n_out_valid = '0;
        for (int k = 0; k < NN; k++) vals[k] = '0;
        tick(2);
        @(negedge clk);
        chk_all_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(2);

        set_want(5, -3, 7, 1);
        frame(0, 0, 0, 0);
        frame(1, 0, 0, 0);
        set_want($urandom, $urandom, $urandom, $urandom);
        frame(0, 1, 0, 0);
        set_want(5, -3, 7, 1);
        frame(2, 0, 2, 0);
        frame(0, 0, 0, 1);

        feed(5, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        tick(1);
        rst = 1'b0;
        exp_err = 1'b0;
        tick(1);
        set_want(5, -3, 7, 7);
        frame(0, 0, 0, 0);

        for (int f = 0; f < 8; f++) begin
            set_want($urandom, $urandom, $urandom, $urandom);
            frame(2, 2, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
